// File: rtl/ram_console_ctrl.sv
// Register-bank plus RAM console: switch loads, direct/auto-increment RAM writes,
// zero-fill sweep and LED mux. Define RAM_COPY_EN to add the RAM-to-register copy (cp_pulse).
module ram_console_ctrl #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 6,
  parameter  int NREG   = 4,
  localparam int SEL_W  = $clog2(NREG),
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              ld_pulse,
  input  logic              wr_pulse,
  input  logic              clr_pulse,
  input  logic              show_reg,
  input  logic              auto_inc,
`ifdef RAM_COPY_EN
  input  logic              cp_pulse,
`endif
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy,
  output logic              drop
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              auto_inc_q, auto_inc_d;
  logic              drop_q, drop_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              rise;
  logic              cp_req;
  logic              wr_acc;
  logic              cp_acc;
  logic [ADDR_W-1:0] eaddr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] sel_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef RAM_COPY_EN
  assign cp_req = cp_pulse;
`else
  assign cp_req = 1'b0;
`endif

  // The pointer only takes over once auto_inc has been high for a full cycle;
  // on the rising cycle the direct address is both used and preloaded.
  always_comb begin
    idle     = (state_q == ST_IDLE);
    rise     = auto_inc & ~auto_inc_q;
    eaddr    = (rst && auto_inc && auto_inc_q) ? ptr_q : addr_in;
    wr_acc   = rst & wr_pulse & idle & ~clr_pulse;
    cp_acc   = rst & cp_req & idle & ~clr_pulse;
    rd_word  = mem[eaddr];
    sel_word = regs_q[reg_sel];
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ptr_d      = ptr_q;
    auto_inc_d = auto_inc;
    drop_d     = drop_q;
    regs_d     = regs_q;
    mem_we     = 1'b0;
    mem_waddr  = eaddr;
    mem_wdata  = sel_word;

    case (state_q)
      ST_IDLE: begin
        if (clr_pulse) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase

    if (wr_acc) mem_we = 1'b1;

    if ((wr_pulse && !wr_acc) || (cp_req && !cp_acc)) drop_d = 1'b1;

    if (rise) ptr_d = addr_in;
    if ((wr_acc || cp_acc) && auto_inc) ptr_d = eaddr + ADDR_W'(1);

    // A same-cycle load overrides the copy; the copy sees the pre-edge RAM word.
    if (ld_pulse)    regs_d[reg_sel] = d_in;
    else if (cp_acc) regs_d[reg_sel] = rd_word;

    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      ptr_q      <= '0;
      auto_inc_q <= 1'b0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b1;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ptr_q      <= ptr_d;
      auto_inc_q <= auto_inc_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      regs_q     <= regs_d;
    end
  end

  // RAM is never cleared by reset itself, only by the sweep.
  always_ff @(posedge clk_out) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    addr_out = eaddr;
    busy     = ~rst | busy_q;
    drop     = rst & drop_q;
    if (!rst)          d_out = '0;
    else if (show_reg) d_out = sel_word;
    else if (busy_q)   d_out = '0;
    else               d_out = rd_word;
  end

endmodule

// File: doc/ram_console_ctrl.md
Name: ram_console_ctrl

Overview:
Parametrised register-bank plus RAM console for the lab board. It is driven by single-cycle pulses that are already debounced and edge-detected upstream in the clk_out domain. Features:
- loads a selectable working register from switches
- writes a register into RAM at a direct or auto-incrementing address
- sweeps RAM to zero on command and out of reset
- muxes register or RAM contents to the LEDs

Parameters:
DATA_W, 8, data word width
ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W
NREG, 4, number of working registers (power of 2, >=2); SEL_W = log2(NREG)

Ports:
clk_out  input  1  system clock (divided board clock)
rst  input  1  synchronous, active-low reset
ld_pulse  input  1  load reg[reg_sel] <= d_in
wr_pulse  input  1  write reg[reg_sel] to RAM at effective address
clr_pulse  input  1  start zero-fill sweep of RAM
show_reg  input  1  1: d_out shows reg[reg_sel]; 0: d_out shows RAM word
auto_inc  input  1  1: effective address from internal pointer; 0: from addr_in
reg_sel  input  SEL_W  working register select
addr_in  input  ADDR_W  direct address / pointer preload value
d_in  input  DATA_W  load data
d_out  output  DATA_W  display data
addr_out  output  ADDR_W  current effective address
busy  output  1  clear sweep in progress
drop  output  1  sticky: a write (or copy) command was discarded

Behaviour:
- Reset: rst is synchronous, active-low, clock clk_out; all state updates on posedge clk_out.
- While rst=0, every cycle:
  - all regs = 0, ptr = 0, auto_inc_q = 0, drop = 0
  - FSM = CLEAR, clr_idx = 0, busy = 1
  - d_out = 0, addr_out = addr_in
- FSM states IDLE and CLEAR; busy = (state == CLEAR).
- CLEAR sweep:
  - each cycle writes 0 to mem[clr_idx], then clr_idx += 1
  - at clr_idx == DEPTH-1 the write occurs and the next state is IDLE
  - sweep takes exactly DEPTH cycles; busy falls the cycle after address DEPTH-1 is written
- IDLE + clr_pulse: next state CLEAR, clr_idx = 0. clr_pulse while in CLEAR is ignored (no restart).
- Effective address eaddr:
  - auto_inc=0: eaddr = addr_in
  - auto_inc=1: eaddr = ptr, except in the rise cycle (auto_inc=1, auto_inc_q=0), where eaddr = addr_in
  - addr_out = eaddr
- Pointer:
  - on the auto_inc rise cycle, ptr <= addr_in
  - an accepted write with auto_inc=1 sets ptr <= eaddr+1, wrapping DEPTH-1 -> 0
  - both in one cycle gives ptr = addr_in+1
- ld_pulse: reg[reg_sel] <= d_in. Always accepted, including while busy.
- wr_pulse accepted only when state==IDLE and clr_pulse=0; then mem[eaddr] <= reg[reg_sel].
  - The write uses the pre-edge register value, so a same-cycle ld to the same register does not affect written data.
  - A rejected wr_pulse sets drop = 1, and ptr does not advance.
- drop is cleared only by reset.
- d_out is combinational, with RAM read asynchronously:
  - show_reg=1: reg[reg_sel]
  - show_reg=0 and busy=0: mem[eaddr]
  - show_reg=0 and busy=1: 0
- RAM contents are not otherwise affected by reset (only via sweep).

Optional Feature:
Macro RAM_COPY_EN.
- Defined: adds input cp_pulse (1 bit). In IDLE with clr_pulse=0, cp_pulse sets reg[reg_sel] <= mem[eaddr] and advances ptr exactly like a write when auto_inc=1.
  - ld_pulse wins over cp_pulse in the same cycle.
  - wr_pulse and cp_pulse together: both execute. RAM gets the old register value, the register gets the old RAM value, and ptr advances once.
  - cp_pulse while busy or with clr_pulse: dropped, drop = 1.
- Undefined: port cp_pulse absent; no RAM-to-register path.

Test Plan:
- Reset sweep: hold rst=0 3 cycles, release -> busy=1 for exactly 64 cycles, then 0. With show_reg=0, every addr_in 0..63 reads d_out=0x00; drop=0.
- Direct write/read: reg_sel=2, ld d_in=0xA5, addr_in=0x3F, wr, show_reg=0 -> d_out=0xA5. show_reg=1, reg_sel=1 -> d_out=0x00.
- Auto-increment wrap: addr_in=62, raise auto_inc, ld 0x11/wr, ld 0x22/wr, ld 0x33/wr -> mem[62]=0x11, mem[63]=0x22, mem[0]=0x33; addr_out=1.
- Clear collision: wr_pulse in same cycle as clr_pulse, and again 10 cycles into the sweep -> neither write lands. drop=1 stays set; RAM all 0 after 64 cycles; ld during sweep still updates the register.
- Same-cycle ld+wr: reg0=0x0F, then ld d_in=0xF0 with wr to addr 5 -> mem[5]=0x0F, reg0=0xF0.
- RAM_COPY_EN: mem[7]=0x5A, auto_inc=0, addr_in=7, reg_sel=3, cp_pulse -> reg3=0x5A. cp+ld same cycle with d_in=0x99 -> reg3=0x99.
